// File: rtl/scanner_arbiter_pkg.sv
// Shared types, field widths and the round-robin lane search for scanner_arbiter.
package scanner_arbiter_pkg;

  typedef enum logic {D_IDLE, D_SEND} dstate_t;

  localparam int CMD_W  = 8;
  localparam int ID_W   = 32;
  localparam int DATA_W = 256;
  localparam int BVLD_W = 32;

  // First non-busy lane at or above ptr, wrapping modulo n (n <= 8).
  // Scanning downward lets the nearest hit overwrite farther ones.
  function automatic logic [2:0] rr_pick(input logic [7:0] busy, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int unsigned k = n; k > 0; k--) begin
      idx = 3'((32'(ptr) + k - 1) % n);
      if (!busy[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/scanner_arb_ofifo.sv
// Dispatch-order FIFO: remembers which lane each outstanding packet went to.
module scanner_arb_ofifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;

  assign do_pop = pop & (cnt != '0);
  assign head   = mem[rd_ptr];
  assign empty  = (cnt == '0);
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  ovf_chk: assert property (@(posedge clk) disable iff (reset)
                            !(push && !do_pop && cnt == CW'(DEPTH)));

endmodule

// File: rtl/scanner_arbiter.sv
// Shares NUM_SCN scanner lanes: round-robin whole-packet dispatch, in-order result collection.
module scanner_arbiter
  import scanner_arbiter_pkg::*;
#(
  parameter int NUM_SCN = 4,
  parameter int LW      = $clog2(NUM_SCN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ctrl_en_arb,
  input  logic                        dpt_dvld_arb,
  input  logic [CMD_W-1:0]            dpt_cmd_arb,
  input  logic [ID_W-1:0]             dpt_id_arb,
  input  logic [31:0]                 dpt_poff_arb,
  input  logic [DATA_W-1:0]           dpt_data_arb,
  input  logic [BVLD_W-1:0]           dpt_bvld_arb,
  input  logic                        dpt_end_arb,
  output logic                        arb_rdy_dpt,
  output logic [NUM_SCN-1:0]          arb_en_scn,
  output logic [NUM_SCN-1:0]          arb_dvld_scn,
  output logic [CMD_W-1:0]            arb_cmd_scn,
  output logic [ID_W-1:0]             arb_id_scn,
  output logic [31:0]                 arb_poff_scn,
  output logic [DATA_W-1:0]           arb_data_scn,
  output logic [BVLD_W-1:0]           arb_bvld_scn,
  output logic [NUM_SCN-1:0]          arb_end_scn,
  input  logic [NUM_SCN-1:0]          scn_rdy_arb,
  input  logic [NUM_SCN-1:0]          scn_dvld_arb,
  input  logic [NUM_SCN-1:0]          scn_end_arb,
  input  logic [NUM_SCN*CMD_W-1:0]    scn_cmd_arb,
  input  logic [NUM_SCN*ID_W-1:0]     scn_id_arb,
  input  logic [NUM_SCN*DATA_W-1:0]   scn_data_arb,
  input  logic [NUM_SCN*BVLD_W-1:0]   scn_bvld_arb,
  output logic [NUM_SCN-1:0]          arb_rdy_scn,
  output logic                        arb_dvld_clt,
  output logic [CMD_W-1:0]            arb_cmd_clt,
  output logic [ID_W-1:0]             arb_id_clt,
  output logic [DATA_W-1:0]           arb_data_clt,
  output logic [BVLD_W-1:0]           arb_bvld_clt,
  output logic                        arb_end_clt,
  input  logic                        clt_rdy_arb,
  output logic [31:0]                 arb_pkt_cnt,
  output logic [31:0]                 arb_res_cnt
);

  dstate_t                      state;
  logic [LW-1:0]                cur_lane, rr_ptr, pick, head, sel;
  logic [NUM_SCN-1:0]           lane_busy, set_mask, clr_mask;
  logic                         fifo_empty, pkt_done, xfer;
  logic [$clog2(NUM_SCN+1)-1:0] ord_cnt;

  assign pick = LW'(rr_pick(8'(lane_busy), 3'(rr_ptr), NUM_SCN));

  // Ready depends only on state and the chosen lane, never on dispatcher valid.
  assign arb_rdy_dpt = (state == D_SEND) & scn_rdy_arb[cur_lane];
  assign pkt_done    = dpt_dvld_arb & arb_rdy_dpt & dpt_end_arb;

  assign arb_en_scn   = {NUM_SCN{ctrl_en_arb}};
  assign arb_cmd_scn  = dpt_cmd_arb;
  assign arb_id_scn   = dpt_id_arb;
  assign arb_poff_scn = dpt_poff_arb;
  assign arb_data_scn = dpt_data_arb;
  assign arb_bvld_scn = dpt_bvld_arb;

  always_comb begin
    arb_dvld_scn = '0;
    arb_end_scn  = '0;
    if (state == D_SEND) begin
      arb_dvld_scn[cur_lane] = dpt_dvld_arb;
      arb_end_scn[cur_lane]  = dpt_end_arb;
    end
  end

  // Lane 0 is selected while nothing is outstanding so the collector fields stay deterministic.
  assign sel          = fifo_empty ? '0 : head;
  assign arb_dvld_clt = ~fifo_empty & scn_dvld_arb[sel];
  assign arb_cmd_clt  = scn_cmd_arb[sel*CMD_W +: CMD_W];
  assign arb_id_clt   = scn_id_arb[sel*ID_W +: ID_W];
  assign arb_data_clt = scn_data_arb[sel*DATA_W +: DATA_W];
  assign arb_bvld_clt = scn_bvld_arb[sel*BVLD_W +: BVLD_W];
  assign arb_end_clt  = scn_end_arb[sel];
  assign xfer         = arb_dvld_clt & clt_rdy_arb;

  always_comb begin
    arb_rdy_scn = '0;
    if (!fifo_empty) arb_rdy_scn[sel] = clt_rdy_arb;
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pkt_done) set_mask[cur_lane] = 1'b1;
    if (xfer)     clr_mask[sel]      = 1'b1;
  end

  scanner_arb_ofifo #(.DEPTH(NUM_SCN), .W(LW)) u_ofifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pkt_done),
    .push_data (cur_lane),
    .pop       (xfer),
    .head      (head),
    .empty     (fifo_empty),
    .count     (ord_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= D_IDLE;
      cur_lane    <= '0;
      rr_ptr      <= '0;
      lane_busy   <= '0;
      arb_pkt_cnt <= '0;
      arb_res_cnt <= '0;
    end else begin
      lane_busy <= (lane_busy | set_mask) & ~clr_mask;
      if (xfer) arb_res_cnt <= arb_res_cnt + 1'b1;
      case (state)
        D_IDLE: if (dpt_dvld_arb && ctrl_en_arb && (~lane_busy != '0)) begin
          cur_lane <= pick;
          state    <= D_SEND;
        end
        D_SEND: if (pkt_done) begin
          rr_ptr      <= LW'(cur_lane + 1'b1);
          arb_pkt_cnt <= arb_pkt_cnt + 1'b1;
          state       <= D_IDLE;
        end
        default: state <= D_IDLE;
      endcase
    end
  end

  // Every outstanding order entry corresponds to exactly one busy lane.
  ord_chk: assert property (@(posedge clk) disable iff (reset)
                            32'(ord_cnt) == $countones(lane_busy));

endmodule

// File: tb/tb_scanner_arbiter.sv
// Directed bench for scanner_arbiter: dispatch order, in-order collection, stalls and reset.
module tb_scanner_arbiter;
  localparam int NUM_SCN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, ctrl_en_arb, dpt_dvld_arb, dpt_end_arb, arb_rdy_dpt;
  logic [7:0]            dpt_cmd_arb, arb_cmd_scn, arb_cmd_clt;
  logic [31:0]           dpt_id_arb, dpt_poff_arb, dpt_bvld_arb;
  logic [255:0]          dpt_data_arb, arb_data_scn, arb_data_clt;
  logic [31:0]           arb_id_scn, arb_poff_scn, arb_bvld_scn, arb_id_clt, arb_bvld_clt;
  logic [NUM_SCN-1:0]    arb_en_scn, arb_dvld_scn, arb_end_scn, arb_rdy_scn;
  logic [NUM_SCN-1:0]    scn_rdy_arb, scn_dvld_arb, scn_end_arb;
  logic [NUM_SCN*8-1:0]  scn_cmd_arb;
  logic [NUM_SCN*32-1:0] scn_id_arb, scn_bvld_arb;
  logic [NUM_SCN*256-1:0] scn_data_arb;
  logic                  arb_dvld_clt, arb_end_clt, clt_rdy_arb;
  logic [31:0]           arb_pkt_cnt, arb_res_cnt;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  scanner_arbiter #(.NUM_SCN(NUM_SCN)) dut (
    .clk(clk), .reset(reset), .ctrl_en_arb(ctrl_en_arb),
    .dpt_dvld_arb(dpt_dvld_arb), .dpt_cmd_arb(dpt_cmd_arb), .dpt_id_arb(dpt_id_arb),
    .dpt_poff_arb(dpt_poff_arb), .dpt_data_arb(dpt_data_arb), .dpt_bvld_arb(dpt_bvld_arb),
    .dpt_end_arb(dpt_end_arb), .arb_rdy_dpt(arb_rdy_dpt), .arb_en_scn(arb_en_scn),
    .arb_dvld_scn(arb_dvld_scn), .arb_cmd_scn(arb_cmd_scn), .arb_id_scn(arb_id_scn),
    .arb_poff_scn(arb_poff_scn), .arb_data_scn(arb_data_scn), .arb_bvld_scn(arb_bvld_scn),
    .arb_end_scn(arb_end_scn), .scn_rdy_arb(scn_rdy_arb), .scn_dvld_arb(scn_dvld_arb),
    .scn_end_arb(scn_end_arb), .scn_cmd_arb(scn_cmd_arb), .scn_id_arb(scn_id_arb),
    .scn_data_arb(scn_data_arb), .scn_bvld_arb(scn_bvld_arb), .arb_rdy_scn(arb_rdy_scn),
    .arb_dvld_clt(arb_dvld_clt), .arb_cmd_clt(arb_cmd_clt), .arb_id_clt(arb_id_clt),
    .arb_data_clt(arb_data_clt), .arb_bvld_clt(arb_bvld_clt), .arb_end_clt(arb_end_clt),
    .clt_rdy_arb(clt_rdy_arb), .arb_pkt_cnt(arb_pkt_cnt), .arb_res_cnt(arb_res_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane_res(input int i, input logic v, input logic [31:0] id, input logic [255:0] d);
    scn_dvld_arb[i]          = v;
    scn_end_arb[i]           = v;
    scn_id_arb[i*32 +: 32]   = id;
    scn_data_arb[i*256 +: 256] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy_dpt"},  arb_rdy_dpt, 0);
    chk({tag, "_dvld_scn"}, arb_dvld_scn, 0);
    chk({tag, "_rdy_scn"},  arb_rdy_scn, 0);
    chk({tag, "_dvld_clt"}, arb_dvld_clt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; ctrl_en_arb = 1; clt_rdy_arb = 1; scn_rdy_arb = '1;
    dpt_dvld_arb = 0; dpt_end_arb = 0; dpt_cmd_arb = 8'h3C; dpt_id_arb = 0;
    dpt_poff_arb = 32'h40; dpt_data_arb = '0; dpt_bvld_arb = '1;
    scn_dvld_arb = '0; scn_end_arb = '0; scn_cmd_arb = '0; scn_id_arb = '0;
    scn_data_arb = '0; scn_bvld_arb = '0;
    tick(); tick();
    chk_quiet("rst");
    chk("rst_pkt", arb_pkt_cnt, 0);
    chk("rst_res", arb_res_cnt, 0);

    // Single two-beat packet to lane 0, result returned immediately.
    reset = 0; dpt_dvld_arb = 1; dpt_id_arb = 32'h11; #1;
    chk("p1_idle_rdy", arb_rdy_dpt, 0);
    tick();
    chk("p1_dvld_scn", arb_dvld_scn, 4'b0001);
    chk("p1_rdy_dpt", arb_rdy_dpt, 1);
    chk("p1_id_scn", arb_id_scn, 32'h11);
    chk("p1_end_b1", arb_end_scn, 4'b0000);
    tick();
    dpt_end_arb = 1; #1;
    chk("p1_end_b2", arb_end_scn, 4'b0001);
    tick();
    dpt_dvld_arb = 0; dpt_end_arb = 0; lane_res(0, 1, 32'h11, 256'hA5); #1;
    chk("p1_pkt_cnt", arb_pkt_cnt, 1);
    chk("p1_dvld_clt", arb_dvld_clt, 1);
    chk("p1_id_clt", arb_id_clt, 32'h11);
    chk("p1_data_clt", arb_data_clt, 256'hA5);
    chk("p1_rdy_scn", arb_rdy_scn, 4'b0001);
    tick();
    lane_res(0, 0, 0, 0); #1;
    chk("p1_res_cnt", arb_res_cnt, 1);
    chk("p1_clt_idle", arb_dvld_clt, 0);

    // Four one-beat packets fill lanes 0..3; a fifth stalls until lane 0 drains.
    reset = 1; tick(); reset = 0;
    dpt_dvld_arb = 1; dpt_end_arb = 1; dpt_id_arb = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_lane%0d", i), arb_dvld_scn, 4'b0001 << i);
      tick();
    end
    chk("rr_pkt_cnt", arb_pkt_cnt, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_stall_rdy", arb_rdy_dpt, 0);
      chk("full_stall_dvld", arb_dvld_scn, 0);
    end
    lane_res(0, 1, 32'h20, 256'h1); #1;
    chk("full_head_dvld", arb_dvld_clt, 1);
    tick();
    lane_res(0, 0, 0, 0); #1;
    chk("free_next_cycle_rdy", arb_rdy_dpt, 0);
    tick();
    chk("fifth_lane0", arb_dvld_scn, 4'b0001);
    tick();
    dpt_dvld_arb = 0; #1;
    chk("fifth_pkt_cnt", arb_pkt_cnt, 5);

    // Out-of-order completion: lanes finish 2,0,1 but leave in dispatch order.
    reset = 1; tick(); reset = 0;
    dpt_dvld_arb = 1; dpt_end_arb = 1;
    for (int i = 0; i < 3; i++) begin
      dpt_id_arb = 32'h30 + 32'(i);
      tick(); tick();
    end
    dpt_dvld_arb = 0;
    lane_res(2, 1, 32'h32, 256'h302); #1;
    chk("ooo_wait_dvld", arb_dvld_clt, 0);
    chk("ooo_wait_rdy", arb_rdy_scn, 4'b0001);
    clt_rdy_arb = 0; lane_res(0, 1, 32'h30, 256'h300); #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_dvld", arb_dvld_clt, 1);
      chk("hold_id", arb_id_clt, 32'h30);
      chk("hold_rdy_scn", arb_rdy_scn, 0);
      chk("hold_res_cnt", arb_res_cnt, 0);
      tick();
    end
    clt_rdy_arb = 1; #1;
    chk("ooo_rdy0", arb_rdy_scn, 4'b0001);
    tick();
    lane_res(0, 0, 0, 0); #1;
    chk("ooo_res1", arb_res_cnt, 1);
    chk("ooo_head1_dvld", arb_dvld_clt, 0);
    chk("ooo_rdy1", arb_rdy_scn, 4'b0010);
    lane_res(1, 1, 32'h31, 256'h301); #1;
    chk("ooo_id1", arb_id_clt, 32'h31);
    tick();
    lane_res(1, 0, 0, 0); #1;
    chk("ooo_id2", arb_id_clt, 32'h32);
    chk("ooo_data2", arb_data_clt, 256'h302);
    chk("ooo_rdy2", arb_rdy_scn, 4'b0100);
    tick();
    lane_res(2, 0, 0, 0); #1;
    chk("ooo_res3", arb_res_cnt, 3);
    chk("ooo_drained", arb_dvld_clt, 0);

    // Enable gating; deassert mid-packet lets the packet finish (goes to lane 3).
    ctrl_en_arb = 0; dpt_dvld_arb = 1; dpt_end_arb = 0; #1;
    chk("en_scn_low", arb_en_scn, 4'b0000);
    repeat (3) tick();
    chk("en_low_rdy", arb_rdy_dpt, 0);
    chk("en_low_pkt", arb_pkt_cnt, 3);
    ctrl_en_arb = 1; tick();
    chk("en_lane3", arb_dvld_scn, 4'b1000);
    ctrl_en_arb = 0; scn_rdy_arb[3] = 0; #1;
    chk("lane_bp_rdy", arb_rdy_dpt, 0);
    tick();
    scn_rdy_arb[3] = 1; #1;
    chk("mid_en_rdy", arb_rdy_dpt, 1);
    chk("mid_en_dvld", arb_dvld_scn, 4'b1000);
    tick();
    dpt_end_arb = 1; tick();
    chk("mid_en_done", arb_pkt_cnt, 4);
    tick(); tick();
    chk("en_low_after", arb_rdy_dpt, 0);
    chk("en_low_after_dvld", arb_dvld_scn, 0);

    // Reset during beat 2 of a packet headed for lane 1.
    ctrl_en_arb = 1; tick();
    chk("pre_rst_lane0", arb_dvld_scn, 4'b0001);
    tick();
    dpt_end_arb = 0; tick();
    chk("pre_rst_lane1", arb_dvld_scn, 4'b0010);
    tick();
    dpt_end_arb = 1; reset = 1; tick();
    chk_quiet("mid_rst");
    chk("mid_rst_pkt", arb_pkt_cnt, 0);
    chk("mid_rst_res", arb_res_cnt, 0);
    reset = 0; tick();
    chk("post_rst_lane0", arb_dvld_scn, 4'b0001);
    tick();
    dpt_dvld_arb = 0; #1;
    chk("post_rst_pkt", arb_pkt_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/scanner_arbiter.md
# scanner_arbiter

Shares NUM_SCN scanner lanes between one dispatcher stream and one collector. Whole packets from the dispatcher go to idle lanes in round-robin order, so no lane ever holds two packets. One-beat results come back from the lanes and go to the collector in the same order the packets were dispatched. The block sits between the dispatcher and the scanner-lane array, and between the lane array and the collector.

## Interface
Parameters:
- NUM_SCN, 4: number of scanner lanes; power of two, 2..8.
- LW, $clog2(NUM_SCN): lane-index width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- ctrl_en_arb  in  1  permits new packet dispatch; copied to every lane enable.
- dpt_dvld_arb / dpt_cmd_arb / dpt_id_arb / dpt_poff_arb  in  1/8/32/32  dispatcher beat valid and header fields.
- dpt_data_arb / dpt_bvld_arb / dpt_end_arb  in  256/32/1  beat payload, byte valids, last-beat flag.
- arb_rdy_dpt  out  1  beat accepted when dpt_dvld_arb & arb_rdy_dpt.
- arb_en_scn  out  NUM_SCN  per-lane enable (= ctrl_en_arb).
- arb_dvld_scn  out  NUM_SCN  per-lane beat valid.
- arb_cmd_scn / arb_id_scn / arb_poff_scn / arb_data_scn / arb_bvld_scn  out  8/32/32/256/32  beat fields, broadcast to all lanes.
- arb_end_scn  out  NUM_SCN  per-lane last-beat flag.
- scn_rdy_arb  in  NUM_SCN  per-lane beat ready.
- scn_dvld_arb / scn_end_arb  in  NUM_SCN  per-lane result valid and end.
- scn_cmd_arb / scn_id_arb / scn_data_arb / scn_bvld_arb  in  NUM_SCN×8/×32/×256/×32  per-lane result fields; lane i occupies bits [i*W +: W].
- arb_rdy_scn  out  NUM_SCN  per-lane result ready.
- arb_dvld_clt / arb_cmd_clt / arb_id_clt / arb_data_clt / arb_bvld_clt / arb_end_clt  out  1/8/32/256/32/1  result toward the collector.
- clt_rdy_arb  in  1  collector ready.
- arb_pkt_cnt / arb_res_cnt  out  32/32  dispatched-packet and delivered-result counters.

## Operation
Dispatch FSM:
- D_IDLE
  - arb_rdy_dpt = 0 and all arb_dvld_scn = 0.
  - Leave when dpt_dvld_arb & ctrl_en_arb & (~lane_busy != 0).
  - Pick the first non-busy lane found searching upward from rr_ptr, wrapping modulo NUM_SCN.
  - Register the pick in cur_lane and go to D_SEND.
- D_SEND
  - arb_dvld_scn[cur_lane] = dpt_dvld_arb; arb_end_scn[cur_lane] = dpt_end_arb; all other lanes get 0.
  - arb_rdy_dpt = scn_rdy_arb[cur_lane].
  - On an accepted beat with dpt_end_arb = 1:
    - set lane_busy[cur_lane];
    - push cur_lane into ord_fifo;
    - rr_ptr <= cur_lane+1 (wraps);
    - arb_pkt_cnt increments;
    - go to D_IDLE.
  - ctrl_en_arb falling mid-packet does not abort the packet.

Collect path:
- ord_fifo: depth NUM_SCN, LW wide. It can never overflow, because every entry matches a busy lane. Overflow is an assertion.
- When ord_fifo is non-empty, head = front entry.
- arb_dvld_clt = scn_dvld_arb[head]. All arb_*_clt fields are muxed from lane head.
- arb_rdy_scn[head] = clt_rdy_arb; all other lanes get 0.
- When ord_fifo is empty: arb_dvld_clt = 0 and arb_rdy_scn = 0.
- On transfer (arb_dvld_clt & clt_rdy_arb):
  - pop ord_fifo;
  - clear lane_busy[head];
  - arb_res_cnt increments (32-bit, wraps).
- Results come only from the head lane. A later lane that finishes early waits.

Boundaries:
- Push and pop in the same cycle: both happen and the occupancy count is unchanged.
- A lane freed in cycle t can be picked no earlier than t+1 (lane_busy is registered).
- All lanes busy: stay in D_IDLE with arb_rdy_dpt = 0.
- Reset in any state:
  - D_IDLE; lane_busy = 0; rr_ptr = 0; ord_fifo empty; counters = 0.
  - Every valid/ready output = 0 on the cycle after reset is sampled.

## Timing
- Reset values:
  - arb_rdy_dpt, arb_dvld_scn, arb_end_scn, arb_rdy_scn, arb_dvld_clt = 0.
  - Data outputs are don't-care in value but deterministic: lane 0 mux.
- Dispatch: the first beat of a packet is accepted no earlier than 1 cycle after dpt_dvld_arb is seen in D_IDLE.
- Following beats pass through combinationally, with zero added latency.
- Result path is fully combinational from lane to collector; zero cycles of latency.
- The ordering state updates on the clock edge of each handshake.
- arb_rdy_dpt must not depend on dpt_dvld_arb. The dispatcher may wait for ready before asserting valid.

## Structure
- Shared package holds:
  - D_IDLE/D_SEND encodings;
  - field widths: CMD_W=8, ID_W=32, DATA_W=256, BVLD_W=32;
  - the round-robin search function.
- One sub-module: scanner_arb_ofifo, a sync FIFO (depth NUM_SCN, width LW) with push, pop, head, empty, count.
- Lane muxes and the FSM stay in the top level.

## Test plan
- Reset, then one 2-beat packet with id=0x11: goes to lane 0. Lane 0 returns data=0xA5: arb_dvld_clt=1 and arb_id_clt=0x11. Counters end at 1/1.
- Four back-to-back 1-beat packets: go to lanes 0,1,2,3 in that order. A fifth packet stalls with arb_rdy_dpt=0 until the lane-0 result is taken, then goes to lane 0.
- Lanes return results in order 2,0,1: the collector still sees lane 0, 1, 2 in that order. Lane 2 is held with arb_rdy_scn[2]=0 until its turn.
- clt_rdy_arb held low for 10 cycles while the head is valid: arb_dvld_clt stays 1 and fields stay stable. The FIFO pop happens only on the handshake.
- ctrl_en_arb=0 with dpt_dvld_arb=1: no dispatch. Deassert mid-packet: the packet completes and no new packet starts.
- Reset asserted during D_SEND beat 2: next cycle all valid/ready outputs = 0 and counters = 0. The next packet goes to lane 0.
